// File: rtl/cor_h_test_sequencer.sv
// Test-side sequencer for the Cor_h correlation pipe's scratch-memory port.
// Loads LOAD_LEN impulse-response words into scratch memory, hands memory to
// Cor_h and pulses its start, waits for done (bounded by TIMEOUT), then reads
// RESULT_LEN result words back and presents them on a valid/ready stream.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   go                          single-cycle run request (honoured only in IDLE)
//   src_data/valid/ready        load-word input stream
//   pipeStart, pipeDone         Cor_h start pulse / done input
//   corHMuxSel                  1 = sequencer owns scratch memory, 0 = Cor_h does
//   testWriteAddr/MemOut/WriteEn  scratch memory write port
//   testReadAddr, memIn         scratch memory read port (one-cycle read latency)
//   res_data/valid/ready        readback output stream
//   busy, seqDone, timeoutErr   status: not idle / run complete / sticky abort
module cor_h_test_sequencer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LOAD_BASE   = 0,
    parameter int unsigned LOAD_LEN    = 40,
    parameter int unsigned RESULT_BASE = 1024,
    parameter int unsigned RESULT_LEN  = 64,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              pipeStart,
    input  logic              pipeDone,
    output logic              corHMuxSel,
    output logic [ADDR_W-1:0] testWriteAddr,
    output logic [DATA_W-1:0] testMemOut,
    output logic              testMemWriteEn,
    output logic [ADDR_W-1:0] testReadAddr,
    input  logic [DATA_W-1:0] memIn,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              seqDone,
    output logic              timeoutErr
);

    localparam int unsigned MaxLen = (LOAD_LEN > RESULT_LEN) ? LOAD_LEN : RESULT_LEN;
    localparam int unsigned CntW   = (MaxLen == 0) ? 1 : $clog2(MaxLen + 1);
    localparam int unsigned TcW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0]   LoadLast   = CntW'(LOAD_LEN - 1);
    localparam logic [CntW-1:0]   ResultLast = CntW'(RESULT_LEN - 1);
    localparam logic [TcW-1:0]    TcLast     = TcW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LoadBase   = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] ResultBase = ADDR_W'(RESULT_BASE);

    typedef enum logic [3:0] {
        StIdle, StLoad, StFlush, StStart, StWait,
        StRdIssue, StRdWait, StRdCap, StOut, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic [TcW-1:0]    tcnt_q, tcnt_d;

    logic              src_ready_d, pipe_start_d, mux_sel_d, we_d;
    logic [ADDR_W-1:0] waddr_d, raddr_d;
    logic [DATA_W-1:0] wdata_d, res_data_d;
    logic              res_valid_d, busy_d, seq_done_d, timeout_err_d;

    logic accept, go_accept, wait_timeout;

    assign accept       = (state_q == StLoad) && src_valid && src_ready;
    assign go_accept    = (state_q == StIdle) && go;
    // pipeDone wins over an expiring timer in the same cycle.
    assign wait_timeout = (state_q == StWait) && !pipeDone && (tcnt_q == TcLast);

    // State and counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    idx_d   = '0;
                    state_d = (LOAD_LEN == 0) ? StFlush : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    idx_d = idx_q + CntW'(1);
                    if (idx_q == LoadLast) state_d = StFlush;
                end
            end
            StFlush:   state_d = StStart;
            StStart: begin
                tcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (pipeDone) begin
                    idx_d   = '0;
                    state_d = (RESULT_LEN == 0) ? StDone : StRdIssue;
                end else if (wait_timeout) begin
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q + TcW'(1);
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait:  state_d = StRdCap;
            StRdCap:   state_d = StOut;
            StOut: begin
                if (res_ready) begin
                    if (idx_q == ResultLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + CntW'(1);
                        state_d = StRdIssue;
                    end
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output next values; every output is a register fed from here.
    always_comb begin
        src_ready_d   = (state_d == StLoad);
        pipe_start_d  = (state_d == StStart);
        mux_sel_d     = !((state_d == StStart) || (state_d == StWait));
        we_d          = accept;
        waddr_d       = accept ? (LoadBase + ADDR_W'(idx_q)) : testWriteAddr;
        wdata_d       = accept ? src_data : testMemOut;
        // Address is set on RD_ISSUE entry and held through RD_WAIT/RD_CAP.
        raddr_d       = (state_d == StRdIssue) ? (ResultBase + ADDR_W'(idx_d)) : testReadAddr;
        res_data_d    = (state_q == StRdCap) ? memIn : res_data;
        res_valid_d   = (state_d == StOut);
        busy_d        = (state_d != StIdle);
        seq_done_d    = (state_d == StDone);
        timeout_err_d = go_accept ? 1'b0 : (wait_timeout ? 1'b1 : timeoutErr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ready      <= 1'b0;
            pipeStart      <= 1'b0;
            corHMuxSel     <= 1'b1;
            testMemWriteEn <= 1'b0;
            testWriteAddr  <= '0;
            testMemOut     <= '0;
            testReadAddr   <= '0;
            res_data       <= '0;
            res_valid      <= 1'b0;
            busy           <= 1'b0;
            seqDone        <= 1'b0;
            timeoutErr     <= 1'b0;
        end else begin
            src_ready      <= src_ready_d;
            pipeStart      <= pipe_start_d;
            corHMuxSel     <= mux_sel_d;
            testMemWriteEn <= we_d;
            testWriteAddr  <= waddr_d;
            testMemOut     <= wdata_d;
            testReadAddr   <= raddr_d;
            res_data       <= res_data_d;
            res_valid      <= res_valid_d;
            busy           <= busy_d;
            seqDone        <= seq_done_d;
            timeoutErr     <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_cor_h_test_sequencer.sv
// Directed bench for cor_h_test_sequencer: nominal run, load stall, readback
// backpressure, WAIT timeout, reset mid-readback, and ignored go/pipeDone.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_cor_h_test_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned LL = 40;
    localparam int unsigned RL = 64;
    localparam int unsigned TO = 300;

    logic          clk = 1'b0;
    logic          reset, go, src_valid, src_ready, pipeStart, pipeDone, corHMuxSel;
    logic          testMemWriteEn, res_valid, res_ready, busy, seqDone, timeoutErr;
    logic [DW-1:0] src_data, testMemOut, memIn, res_data;
    logic [AW-1:0] testWriteAddr, testReadAddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cor_h_test_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .LOAD_BASE(0), .LOAD_LEN(LL),
        .RESULT_BASE(1024), .RESULT_LEN(RL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .pipeStart(pipeStart), .pipeDone(pipeDone), .corHMuxSel(corHMuxSel),
        .testWriteAddr(testWriteAddr), .testMemOut(testMemOut),
        .testMemWriteEn(testMemWriteEn), .testReadAddr(testReadAddr), .memIn(memIn),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .seqDone(seqDone), .timeoutErr(timeoutErr)
    );

    // Memory read model: data encodes the address, one-cycle latency.
    always @(posedge clk) memIn <= 32'hC000_0000 | 32'(testReadAddr);

    // Event log, sampled on the falling edge.
    logic          clr;
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic [DW-1:0] rd_data[$];
    int wr_mux_bad, start_n, done_n, mux_low_n, cyc, last_wr_cyc, start_cyc;

    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            wr_addr.delete(); wr_data.delete(); rd_data.delete();
            wr_mux_bad = 0; start_n = 0; done_n = 0; mux_low_n = 0;
            last_wr_cyc = 0; start_cyc = 0;
        end else begin
            if (testMemWriteEn) begin
                wr_addr.push_back(testWriteAddr);
                wr_data.push_back(testMemOut);
                if (!corHMuxSel) wr_mux_bad++;
                last_wr_cyc = cyc;
            end
            if (pipeStart) begin start_n++; start_cyc = cyc; end
            if (!corHMuxSel) mux_low_n++;
            if (res_valid && res_ready) rd_data.push_back(res_data);
            if (seqDone) done_n++;
        end
    end

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic clear_logs;
        clr = 1'b1; tick; clr = 1'b0;
    endtask

    task automatic start_run;
        go = 1'b1; tick; go = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        `CHK(tag, {corHMuxSel, busy, src_ready, pipeStart, testMemWriteEn, res_valid,
                   seqDone, timeoutErr}, 8'b1000_0000)
        `CHK(tag, {testWriteAddr, testReadAddr, testMemOut, res_data}, 88'h0)
    endtask

    // mode 0: src_valid continuous; mode 1: 1,0,0 repeating.
    task automatic load(input int mode, input bit go_mid);
        int k = 0;
        int g = 0;
        bit ok;
        while (k < int'(LL) && g < 1000) begin
            src_valid = (mode == 0) || (g % 3 == 0);
            src_data  = 32'h1000 + k;
            go        = go_mid && (g == 5);
            ok        = src_valid && src_ready;
            tick;
            if (ok) k++;
            g++;
        end
        src_valid = 1'b0;
        go        = 1'b0;
        `CHK("load_accepts", k, int'(LL))
    endtask

    task automatic wait_start;
        int g = 0;
        while (!pipeStart && g < 100) begin tick; g++; end
        `CHK("start_seen", pipeStart, 1'b1)
        `CHK("mux_at_start", corHMuxSel, 1'b0)
    endtask

    // Called in the START cycle; raises pipeDone d cycles later for one cycle.
    task automatic pipe_done_after(input int d, input bit glitch);
        if (glitch) begin
            pipeDone = 1'b1; tick; pipeDone = 1'b0;
            repeat (d - 1) tick;
        end else begin
            repeat (d) tick;
        end
        pipeDone = 1'b1; tick; pipeDone = 1'b0;
    endtask

    task automatic readback(input int bp_word, input int stop_at, input bit go_mid);
        int g = 0;
        int bad;
        bit bp_done = 1'b0;
        logic [DW-1:0] held;
        while (g < 1500) begin
            if (seqDone) break;
            if (stop_at >= 0 && rd_data.size() == stop_at) break;
            if (bp_word >= 0 && !bp_done && rd_data.size() == bp_word && res_valid) begin
                res_ready = 1'b0;
                held      = res_data;
                `CHK("bp_word", held, 32'hC000_0400 + bp_word)
                bad = 0;
                repeat (10) begin
                    tick;
                    if (!(res_valid === 1'b1 && res_data === held)) bad++;
                end
                `CHK("bp_stable", bad, 0)
                res_ready = 1'b1;
                bp_done   = 1'b1;
            end
            go = go_mid && (g == 7);
            tick;
            g++;
        end
        go = 1'b0;
        if (stop_at < 0) `CHK("seq_done_seen", seqDone, 1'b1)
    endtask

    task automatic check_run(input int exp_mux_low);
        int bad = 0;
        `CHK("wr_count", wr_addr.size(), int'(LL))
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 12'(i) || wr_data[i] !== 32'h1000 + i) bad++;
        `CHK("wr_contig", bad, 0)
        `CHK("wr_mux_owned", wr_mux_bad, 0)
        `CHK("start_pulses", start_n, 1)
        `CHK("last_wr_before_start", (last_wr_cyc < start_cyc), 1'b1)
        `CHK("mux_low_cycles", mux_low_n, exp_mux_low)
        `CHK("rd_count", rd_data.size(), int'(RL))
        bad = 0;
        for (int i = 0; i < rd_data.size(); i++)
            if (rd_data[i] !== 32'hC000_0400 + i) bad++;
        `CHK("rd_order", bad, 0)
        `CHK("done_pulses", done_n, 1)
        `CHK("idle_after", {busy, corHMuxSel, timeoutErr}, 3'b010)
    endtask

    initial begin
        int n;
        reset = 1'b0; go = 1'b0; src_valid = 1'b0; src_data = '0;
        pipeDone = 1'b0; res_ready = 1'b1; clr = 1'b0;
        repeat (2) tick;
        check_reset_vals("reset_state");
        reset = 1'b1;
        tick;

        // Nominal run.
        clear_logs;
        start_run;
        `CHK("load_entry", {busy, src_ready, corHMuxSel}, 3'b111)
        load(0, 1'b0);
        wait_start;
        pipe_done_after(200, 1'b0);
        readback(-1, -1, 1'b0);
        tick;
        check_run(201);

        // Load stall plus readback backpressure on word 5.
        clear_logs;
        start_run;
        load(1, 1'b0);
        wait_start;
        pipe_done_after(200, 1'b0);
        readback(5, -1, 1'b0);
        tick;
        check_run(201);

        // Timeout: pipeDone never arrives.
        clear_logs;
        start_run;
        load(0, 1'b0);
        wait_start;
        n = 0;
        while (!timeoutErr && n < 1000) begin tick; n++; end
        `CHK("timeout_cycles", n, int'(TO) + 1)
        `CHK("timeout_state", {timeoutErr, corHMuxSel, busy}, 3'b110)
        `CHK("timeout_mux_low", mux_low_n, int'(TO) + 1)
        repeat (3) tick;
        `CHK("timeout_no_done", done_n, 0)
        `CHK("timeout_no_rd", rd_data.size(), 0)
        `CHK("timeout_sticky", timeoutErr, 1'b1)
        clear_logs;
        start_run;
        `CHK("go_clears_timeout", timeoutErr, 1'b0)
        load(0, 1'b0);
        wait_start;
        pipe_done_after(200, 1'b0);
        readback(-1, -1, 1'b0);
        tick;
        check_run(201);

        // Reset asserted during readback word 20.
        clear_logs;
        start_run;
        load(0, 1'b0);
        wait_start;
        pipe_done_after(200, 1'b0);
        readback(-1, 20, 1'b0);
        `CHK("rd_before_reset", rd_data.size(), 20)
        reset = 1'b0;
        #1;
        check_reset_vals("reset_midrun");
        tick;
        reset = 1'b1;
        tick;
        clear_logs;
        start_run;
        load(0, 1'b0);
        wait_start;
        pipe_done_after(200, 1'b0);
        readback(-1, -1, 1'b0);
        tick;
        check_run(201);

        // go while busy and a pipeDone glitch in START are both ignored.
        clear_logs;
        start_run;
        load(0, 1'b1);
        wait_start;
        pipe_done_after(50, 1'b1);
        readback(-1, -1, 1'b1);
        tick;
        check_run(51);
        repeat (5) tick;
        `CHK("single_run", {busy, done_n}, {1'b0, 32'd1})

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
